rr_arbiter: RTL
===============

# rr_arbiter

Four-way round-robin arbiter that shares one downstream resource (the encoder-fed datapath) among requesters. It arbitrates on registered state and holds a grant until the owner releases it. With timeout enabled, it also pre-empts an owner that holds the grant too long while others wait. Grants are registered, one-hot, and accompanied by a binary grant index and a valid flag.

## Interface
- N_REQ, 4, number of requesters; fixed at 4 in this revision.
- ID_W, 2, width of the grant index; equals $clog2(N_REQ).
- MAX_HOLD, 4, maximum consecutive grant cycles before pre-emption; legal range 2..255; used only with the timeout feature.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N_REQ  request vector; bit i means requester i wants the resource.
- gnt  output  N_REQ  registered one-hot grant, or all zero.
- gnt_id  output  ID_W  binary index of the granted requester; 0 when idle.
- gnt_valid  output  1  high when gnt is nonzero.
- preempt  output  1  one-cycle pulse on a timeout-forced hand-off.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner = gnt_id.
- Round-robin pointer `ptr` (ID_W bits):
  - Reset value 0.
  - On every new grant, ptr <= winner+1 mod N_REQ.
- Winner selection: first set bit of the candidate vector, scanning ptr, ptr+1, …, wrapping mod N_REQ.
- IDLE:
  - req==0: stay IDLE, outputs 0.
  - req!=0: candidate = req; grant the winner, go to GRANT, hold_cnt <= 1.
- GRANT, owner still requesting (req[owner]==1):
  - Grant is held and hold_cnt increments, saturating at MAX_HOLD.
- GRANT, owner releases (req[owner]==0):
  - candidate = req with the owner bit masked.
  - candidate!=0: hand off to the winner in the same edge (no idle bubble), hold_cnt <= 1.
  - candidate==0: go to IDLE and clear all outputs.
- Timeout (ARB_TIMEOUT_EN only), when hold_cnt==MAX_HOLD and req[owner]==1:
  - If other requests exist: hand off to the winner among req with the owner masked, and pulse preempt for that cycle.
  - If no other requests exist: keep the grant, hold_cnt <= 1, no preempt.
- hold_cnt width is $clog2(MAX_HOLD+1); it never wraps.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt[gnt_id]==1 whenever gnt_valid.
  - preempt implies gnt_valid.
- Reset:
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
  - ptr=0, hold_cnt=0, state IDLE.
  - Reset asserted mid-grant clears everything at the next edge regardless of req.

## Timing
- Latency req→gnt: 1 cycle. req is sampled at posedge k; gnt is valid after posedge k.
- Release→next grant: 1 cycle. The owner drops req before edge k; the new owner is visible after edge k.
- Pre-emption occurs on the edge after the MAX_HOLD-th grant cycle.
  - Example: MAX_HOLD=4 gives 4 cycles of ownership, then the switch.
- preempt is high for exactly the first cycle of the new grant.
- A requester that drops req and re-raises it in the same cycle is indistinguishable from holding; release requires req low at a sampling edge.
- A requester released or pre-empted this edge is masked only for this edge's selection. The updated ptr then gives it lowest priority in the next round.

## Configuration
- ARB_TIMEOUT_EN:
  - Defined: hold_cnt and the pre-emption logic are compiled in, and preempt is driven as specified.
  - Undefined: no hold counter. The grant is held until the owner drops req, and preempt is tied 0.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: rst=1 with req=4'b1111 for 2 cycles -> gnt=0, gnt_id=0, gnt_valid=0, preempt=0. After rst=0 with req=1111 -> gnt=0001, gnt_id=0 one cycle later.
- Single requester: from IDLE, req=0100 -> next cycle gnt=0100, gnt_id=2, valid=1, held while req[2]=1. Drop req to 0 -> next cycle gnt=0, valid=0.
- Back-to-back hand-off: req=0011, owner 0. Drop req to 0010 -> next cycle gnt=0010, gnt_id=1, with no idle cycle.
- Round-robin order: req=1111. Each owner drops its bit for one cycle after being granted -> grant order 0,1,2,3,0, and ptr wraps 3→0.
- Timeout (macro defined, MAX_HOLD=4): req=1111 held constant -> gnt=0001 for 4 cycles, then 0010 with preempt=1 for one cycle, then 0100, 1000, 0001. With req=0001 alone -> gnt stays 0001 and preempt stays 0. Macro undefined with req=1111 -> gnt stays 0001 indefinitely and preempt=0.
- Reset mid-grant: owner 2 holding, assert rst=1 for one cycle -> all outputs 0 next cycle. With req=1111 afterwards -> first grant goes to requester 0.

Source files
------------

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant, held until release.
// Optional owner pre-emption after MAX_HOLD cycles is compiled in with ARB_TIMEOUT_EN.
module rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (N_REQ != 4 || ID_W != 2) begin : g_bad_size
    $error("rr_arbiter supports only N_REQ=4, ID_W=2");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter MAX_HOLD must be in 2..255");
  end

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             pre_q, pre_d;

  logic [N_REQ-1:0] cand;
  logic             owner_req;
  logic             grant_new;
  logic [ID_W-1:0]  win;

  // First set bit of cand scanning from start upward, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] c,
                                              input logic [ID_W-1:0]  start);
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = start + ID_W'(k);
      if (!found && c[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  // The owner's bit is always excluded; in IDLE gnt_q is zero so cand == req.
  assign cand      = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);
  assign win       = rr_pick(cand, ptr_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    pre_d     = 1'b0;
    grant_new = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) grant_new = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          if (|cand) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_W'(MAX_HOLD)) begin
          if (|cand) begin
            grant_new = 1'b1;
            pre_d     = 1'b1;
          end else begin
            hold_d = HOLD_W'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase

    if (grant_new) begin
      state_d = GRANT;
      gnt_d   = N_REQ'(1) << win;
      id_d    = win;
      ptr_d   = win + ID_W'(1);
`ifdef ARB_TIMEOUT_EN
      hold_d  = HOLD_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      pre_q   <= pre_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
  assign preempt = pre_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == GRANT);

endmodule
